// File: rtl/mips_mem_responder_pkg.sv
// Shared types and constants for the MIPS memory responder.
// Holds FSM state encoding, op codes and latency range helpers.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  // Counter preload: latency clamped into range, minus one.
  function automatic logic [3:0] lat_load(input int lat);
    int l;
    l = (lat < LAT_MIN) ? LAT_MIN :
        (lat > LAT_MAX) ? LAT_MAX : lat;
    return 4'(l - 1);
  endfunction

endpackage

// File: rtl/mips_mem_responder_if.sv
// CPU <-> memory responder bus: request, store data, result, status.
// master = CPU side, slave = responder side.
interface mips_mem_responder_if;
  logic [31:0] address;
  logic        memRead;
  logic        memWrite;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;
  logic        error;
  logic        busy;

  modport master (
    output address, memRead, memWrite, writeData,
    input  readData, ready, error, busy
  );

  modport slave (
    input  address, memRead, memWrite, writeData,
    output readData, ready, error, busy
  );
endinterface

// File: rtl/mips_mem_responder_array.sv
// Word array, 32 b wide, sync write and registered read, no reset.
// Ports: clk, we_i/re_i enables, idx_i word index, wdata_i, rdata_o.
module mem_word_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[idx_i];
  end

endmodule

// File: rtl/mips_mem_responder.sv
// Multi-cycle memory responder with programmable latency and errors.
// Ports: clk, rst (async active-low), bus (slave modport).
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input logic                 clk,
  input logic                 rst,
  mips_mem_responder_if.slave bus
);

  localparam logic [3:0] LOAD = lat_load(LATENCY);

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic [31:0]          wdata_q, wdata_d;
  op_e                  op_q, op_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;
  logic                 error_q, error_d;
  logic                 busy_q, busy_d;
  logic                 sel_q, sel_d;
  logic                 fin;
  logic                 we;
  logic                 re;
  logic [31:0]          arr_rdata;
  logic                 unused_addr;

  assign unused_addr = ^bus.address[31:ADDR_BITS+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    err_d   = err_q;
    ready_d = ready_q;
    error_d = error_q;
    busy_d  = busy_q;
    sel_d   = sel_q;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.memRead | bus.memWrite) begin
          idx_d   = bus.address[ADDR_BITS+1:2];
          wdata_d = bus.writeData;
          op_d    = bus.memWrite ? OP_WRITE : OP_READ;
          err_d   = (bus.memRead & bus.memWrite)
                  | (|bus.address[1:0]);
          cnt_d   = LOAD;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          fin     = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          error_d = err_q;
          // readData source: array on good read,
          // zero on error, unchanged on write
          if (err_q) sel_d = 1'b0;
          else if (op_q == OP_READ) sel_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        ready_d = 1'b0;
        error_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign we = fin & ~err_q & (op_q == OP_WRITE);
  assign re = fin & ~err_q & (op_q == OP_READ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      op_q    <= OP_READ;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
    end
  end

  mem_word_array #(.AW(ADDR_BITS)) u_arr (
    .clk     (clk),
    .we_i    (we),
    .re_i    (re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  assign bus.readData = sel_q ? arr_rdata : 32'd0;
  assign bus.ready    = ready_q;
  assign bus.error    = error_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder at LATENCY 2, 1 and 15.
// Instance 0 (L=2) gets the functional tests, all get b2b/busy.
module tb_mips_mem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] addr_a [3];
  logic [31:0] wd_a   [3];
  logic        mr_a   [3];
  logic        mw_a   [3];
  logic [31:0] rd_a   [3];
  logic        rdy_a  [3];
  logic        err_a  [3];
  logic        bsy_a  [3];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    mips_mem_responder_if bus ();
    assign bus.address   = addr_a[g];
    assign bus.writeData = wd_a[g];
    assign bus.memRead   = mr_a[g];
    assign bus.memWrite  = mw_a[g];
    assign rd_a[g]  = bus.readData;
    assign rdy_a[g] = bus.ready;
    assign err_a[g] = bus.error;
    assign bsy_a[g] = bus.busy;
    mips_mem_responder #(
      .ADDR_BITS (10),
      .LATENCY   (L)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] bad);
    checks++;
    assert (obs !== bad) else begin
      failures++;
      $error("FAIL %s observed=%h expected!=%h",
             tag, obs, bad);
    end
  endtask

  // One transaction on instance k. Returns edges from acceptance
  // to ready, busy-high samples, data and error in the ready cycle.
  task automatic txn(input int k,
                     input logic r,
                     input logic w,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input bit hold,
                     output int lat,
                     output int bc,
                     output logic [31:0] rdv,
                     output logic erv);
    mr_a[k]   = r;
    mw_a[k]   = w;
    addr_a[k] = a;
    wd_a[k]   = d;
    @(posedge clk);
    #1;
    bc  = bsy_a[k] ? 1 : 0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (rdy_a[k]) break;
      if (bsy_a[k]) bc++;
    end
    rdv = rd_a[k];
    erv = err_a[k];
    if (!hold) begin
      mr_a[k] = 1'b0;
      mw_a[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("ready_one_cycle", 32'(rdy_a[k]), 32'd0);
  endtask

  int          lat;
  int          bc;
  int          rcnt;
  int          lv;
  logic [31:0] rdv;
  logic        erv;

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_a[i] = 32'd0;
      wd_a[i]   = 32'd0;
      mr_a[i]   = 1'b0;
      mw_a[i]   = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readData", rd_a[0], 32'd0);
    chk("rst_ready", 32'(rdy_a[0]), 32'd0);
    chk("rst_error", 32'(err_a[0]), 32'd0);
    chk("rst_busy", 32'(bsy_a[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // reset one cycle into BUSY discards the write
    mw_a[0]   = 1'b1;
    addr_a[0] = 32'h10;
    wd_a[0]   = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    chk("midrst_busy_pre", 32'(bsy_a[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mw_a[0] = 1'b0;
    #1;
    chk("midrst_busy_in_rst", 32'(bsy_a[0]), 32'd0);
    rcnt = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (rdy_a[0]) rcnt++;
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (rdy_a[0]) rcnt++;
    end
    chk("midrst_no_ready", 32'(rcnt), 32'd0);
    txn(0, 1, 0, 32'h10, 0, 0, lat, bc, rdv, erv);
    chk_ne("midrst_not_written", rdv, 32'hDEADBEEF);

    // basic write/read
    txn(0, 0, 1, 32'h40, 32'h12345678, 0,
        lat, bc, rdv, erv);
    chk("wr40_lat", 32'(lat), 32'd2);
    chk("wr40_err", 32'(erv), 32'd0);
    txn(0, 1, 0, 32'h40, 0, 0, lat, bc, rdv, erv);
    chk("rd40_lat", 32'(lat), 32'd2);
    chk("rd40_data", rdv, 32'h12345678);
    chk("rd40_err", 32'(erv), 32'd0);

    // misaligned
    txn(0, 1, 0, 32'h41, 0, 0, lat, bc, rdv, erv);
    chk("mis_rd_lat", 32'(lat), 32'd2);
    chk("mis_rd_err", 32'(erv), 32'd1);
    chk("mis_rd_data", rdv, 32'd0);
    txn(0, 0, 1, 32'h42, 32'hFFFFFFFF, 0,
        lat, bc, rdv, erv);
    chk("mis_wr_err", 32'(erv), 32'd1);
    txn(0, 1, 0, 32'h40, 0, 0, lat, bc, rdv, erv);
    chk("mis_wr_kept", rdv, 32'h12345678);

    // read+write conflict
    txn(0, 0, 1, 32'h8, 32'h0BADF00D, 0,
        lat, bc, rdv, erv);
    txn(0, 1, 1, 32'h8, 32'h11111111, 0,
        lat, bc, rdv, erv);
    chk("cnf_err", 32'(erv), 32'd1);
    chk("cnf_data", rdv, 32'd0);
    txn(0, 1, 0, 32'h8, 0, 0, lat, bc, rdv, erv);
    chk("cnf_prior", rdv, 32'h0BADF00D);
    chk("cnf_rd_err", 32'(erv), 32'd0);

    // wrap; the write leaves readData alone
    txn(0, 0, 1, 32'h1000, 32'hA5A5A5A5, 0,
        lat, bc, rdv, erv);
    chk("wrap_wr_err", 32'(erv), 32'd0);
    chk("wr_keeps_rdata", rdv, 32'h0BADF00D);
    txn(0, 1, 0, 32'h0, 0, 0, lat, bc, rdv, erv);
    chk("wrap_data", rdv, 32'hA5A5A5A5);
    chk("wrap_err", 32'(erv), 32'd0);

    // back-to-back with held request, latency sweep
    for (int k = 0; k < 3; k++) begin
      lv = (k == 0) ? 2 : (k == 1) ? 1 : 15;
      txn(k, 0, 1, 32'h20, 32'hC0DE0000 + k, 1,
          lat, bc, rdv, erv);
      chk("b2b1_lat", 32'(lat), 32'(lv));
      chk("b2b1_busy", 32'(bc), 32'(lv));
      chk("b2b_idle", 32'(bsy_a[k]), 32'd0);
      txn(k, 0, 1, 32'h20, 32'hC0DE0000 + k, 0,
          lat, bc, rdv, erv);
      chk("b2b2_lat", 32'(lat), 32'(lv));
      chk("b2b2_busy", 32'(bc), 32'(lv));
      txn(k, 1, 0, 32'h20, 0, 0, lat, bc, rdv, erv);
      chk("b2b_rd", rdv, 32'hC0DE0000 + k);
      chk("b2b_rd_lat", 32'(lat), 32'(lv));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
